// File: rtl/weighted_rr_arbiter_if.sv
// weighted_rr_arbiter_if: request/grant bundle between requesters and the weighted round-robin arbiter
//   master : drives req, hold, flush, cfg_weight, cfg_load; observes grant, grant_valid, grant_id, quantum_left
//   slave  : the arbiter side of the same signals
interface weighted_rr_arbiter_if #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4
);
    logic [N-1:0]          req;
    logic [N-1:0]          hold;
    logic [N-1:0]          flush;
    logic [N*WEIGHT_W-1:0] cfg_weight;
    logic                  cfg_load;
    logic [N-1:0]          grant;
    logic                  grant_valid;
    logic [$clog2(N)-1:0]  grant_id;
    logic [WEIGHT_W-1:0]   quantum_left;

    modport master (
        output req, hold, flush, cfg_weight, cfg_load,
        input  grant, grant_valid, grant_id, quantum_left
    );

    modport slave (
        input  req, hold, flush, cfg_weight, cfg_load,
        output grant, grant_valid, grant_id, quantum_left
    );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: zero-latency weighted round-robin arbiter over N requesters
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (ptr=N-1, cnt=0, all weights 1)
//   bus   : slave side of weighted_rr_arbiter_if (req/hold/flush/cfg in, grant/id/quantum out)
module weighted_rr_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    weighted_rr_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cnt_q, cnt_d;
    logic [WEIGHT_W-1:0] weight_q [N];
    logic [N-1:0]        eligible;
    logic                keep;
    logic                found;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     idx;
    logic [WEIGHT_W-1:0] eff_weight;

    always_comb begin
        eligible = bus.req & ~bus.hold & ~bus.flush;
        keep     = eligible[ptr_q] && (cnt_q != '0);
        winner   = ptr_q;
        found    = 1'b0;
        idx      = ptr_q;
        // Scan farthest-first so the nearest eligible index after ptr wins; k=N revisits ptr last.
        for (int k = N; k >= 1; k--) begin
            idx = ptr_q + ID_W'(k);
            if (eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        winner     = keep ? ptr_q : winner;
        eff_weight = (weight_q[winner] == '0) ? WEIGHT_W'(1) : weight_q[winner];
        ptr_d      = found ? winner : ptr_q;
        // An idle cycle keeps the quantum, unless the owner is flushed, which forfeits it.
        cnt_d      = found ? (keep ? cnt_q - WEIGHT_W'(1) : eff_weight - WEIGHT_W'(1))
                           : (bus.flush[ptr_q] ? '0 : cnt_q);
        bus.grant        = found ? (N'(1) << winner) : '0;
        bus.grant_valid  = found;
        bus.grant_id     = found ? winner : '0;
        bus.quantum_left = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(N - 1);
            cnt_q <= '0;
            for (int i = 0; i < N; i++) weight_q[i] <= WEIGHT_W'(1);
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (bus.cfg_load)
                for (int i = 0; i < N; i++) weight_q[i] <= bus.cfg_weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: table-driven directed checks of weighted_rr_arbiter plus an async-reset sequence
module tb_weighted_rr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    weighted_rr_arbiter_if #(.N(4), .WEIGHT_W(4)) bus ();

    weighted_rr_arbiter #(.N(4), .WEIGHT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic [15:0] w;
        bit          ld;
        logic [3:0]  g;
        logic [3:0]  ql;
    } vec_t;

    vec_t tv [$];

    function automatic vec_t v(bit r, logic [3:0] rq, logic [3:0] hd, logic [3:0] fl,
                               logic [15:0] w, bit ld, logic [3:0] g, logic [3:0] ql);
        vec_t t;
        t.rst = r; t.req = rq; t.hold = hd; t.flush = fl;
        t.w = w; t.ld = ld; t.g = g; t.ql = ql;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic run_vec(vec_t t, int idx);
        logic [1:0] eid;
        eid = 2'd0;
        for (int i = 0; i < 4; i++) if (t.g[i]) eid = 2'(i);
        @(negedge clk);
        if (t.rst) begin
            reset = 1'b1;
            #1 reset = 1'b0;
        end
        bus.req = t.req; bus.hold = t.hold; bus.flush = t.flush;
        bus.cfg_weight = t.w; bus.cfg_load = t.ld;
        #1;
        chk("grant", idx, 32'(bus.grant), 32'(t.g));
        chk("grant_valid", idx, 32'(bus.grant_valid), 32'(|t.g));
        chk("grant_id", idx, 32'(bus.grant_id), 32'(eid));
        @(posedge clk);
        #1;
        chk("quantum_left", idx, 32'(bus.quantum_left), 32'(t.ql));
    endtask

    initial begin
        bus.req = '0; bus.hold = '0; bus.flush = '0; bus.cfg_weight = '0; bus.cfg_load = 1'b0;
        // reset state, then plain round-robin with all weights 1
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h0000, 0, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0100, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b1000, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd0));
        // weights w3..w0 = 3,0,0,2 (zero weight behaves as 1)
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h3002, 1, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd1));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0100, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b1000, 4'd2));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b1000, 4'd1));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b1000, 4'd0));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd1));
        tv.push_back(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd0));
        // held owner loses to requester 1, regranted after its quantum
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h4444, 1, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd3));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd2));
        tv.push_back(v(0, 4'b0011, 4'h1, 4'h0, 16'h0000, 0, 4'b0010, 4'd3));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd2));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd1));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd0));
        tv.push_back(v(0, 4'b0011, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd3));
        // weight load coinciding with a quantum load uses the old weight
        tv.push_back(v(1, 4'b0001, 4'h0, 4'h0, 16'h4444, 1, 4'b0001, 4'd0));
        tv.push_back(v(0, 4'b0010, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd3));
        // flushed owner forfeits its quantum, then gets a fresh one
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h4444, 1, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b0100, 4'h0, 4'h0, 16'h0000, 0, 4'b0100, 4'd3));
        tv.push_back(v(0, 4'b0100, 4'h0, 4'h4, 16'h0000, 0, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b0100, 4'h0, 4'h0, 16'h0000, 0, 4'b0100, 4'd3));
        // idle cycles preserve a partial quantum
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h4444, 1, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b0010, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd3));
        tv.push_back(v(0, 4'b0010, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd2));
        for (int i = 0; i < 5; i++)
            tv.push_back(v(0, 4'b0000, 4'h0, 4'h0, 16'h0000, 0, 4'b0000, 4'd2));
        tv.push_back(v(0, 4'b0010, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd1));
        // owner 2 with cnt 3 ahead of the asynchronous reset sequence
        tv.push_back(v(1, 4'b0000, 4'h0, 4'h0, 16'h4444, 1, 4'b0000, 4'd0));
        tv.push_back(v(0, 4'b0100, 4'h0, 4'h0, 16'h0000, 0, 4'b0100, 4'd3));

        foreach (tv[i]) run_vec(tv[i], i);

        // reset mid-cycle: state clears without any clock edge
        #1;
        bus.req = 4'b1111; bus.hold = '0; bus.flush = '0; bus.cfg_load = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset_ql", 100, 32'(bus.quantum_left), 32'd0);
        chk("async_reset_grant", 100, 32'(bus.grant), 32'b0001);
        reset = 1'b0;
        run_vec(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0001, 4'd0), 101);
        run_vec(v(0, 4'b1111, 4'h0, 4'h0, 16'h0000, 0, 4'b0010, 4'd0), 102);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    always @(negedge clk) begin
        assert ($onehot0(bus.grant)) else $error("FAIL onehot grant=%b", bus.grant);
    end
endmodule
